sram_mem_stage: RTL and testbench

MIPS MEM stage. It sits between the EXE/MEM pipeline register and MEM_Stage_reg, and performs data loads and stores against an external synchronous SRAM with a fixed multi-cycle access time. While an access is in flight it holds `ready` low so the pipeline freezes. When the access completes, it presents load data on Mem_Data for MEM_Stage_reg to capture.

---
 rtl/sram_mem_stage.sv | 111 +++++++++++
 tb/tb_sram_mem_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage.sv
// MIPS MEM stage: multi-cycle load/store against a synchronous SRAM.
// Holds ready low for the whole access so the pipeline freezes.
module sram_mem_stage #(
  parameter int          WAIT_CYCLES = 5,
  parameter int          ADDR_W      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_En,
  input  logic              MEM_W_En,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic [31:0]       Mem_Data,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [31:0]       SRAM_WDATA,
  input  logic [31:0]       SRAM_RDATA,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N
);

  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_wr;
  logic [31:0]       r_mem_data;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_ce_n;
  logic              r_we_n;

  logic              w_req;
  logic              w_last;
  logic [31:0]       w_off;
  logic              w_unused;

  assign w_req    = MEM_R_En | MEM_W_En;
  assign w_last   = (r_cnt == LAST);
  assign w_off    = ALU_result - BASE_ADDR;
  // Byte offset to word index; out-of-range addresses just truncate.
  assign w_unused = ^{w_off[31:ADDR_W+2], w_off[1:0]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = ACCESS;
      ACCESS:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_mem_data <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ce_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wr    <= MEM_W_En;
            r_addr  <= w_off[ADDR_W+1:2];
            r_wdata <= ST_val;
            r_cnt   <= '0;
            r_ce_n  <= 1'b0;
            r_we_n  <= ~MEM_W_En;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_ce_n <= 1'b1;
            r_we_n <= 1'b1;
            if (!r_wr) r_mem_data <= SRAM_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // DONE releases the pipeline while the same request is still visible.
  assign ready = !rst
              || (r_state == IDLE && !w_req)
              || (r_state == DONE);

  assign Mem_Data   = r_mem_data;
  assign SRAM_ADDR  = r_addr;
  assign SRAM_WDATA = r_wdata;
  assign SRAM_CE_N  = r_ce_n;
  assign SRAM_WE_N  = r_we_n;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: transaction-level model plus SRAM model,
// directed scenarios followed by randomized instruction streams.
module tb_sram_mem_stage;

  localparam int          W    = 5;
  localparam int          AW   = 16;
  localparam logic [31:0] BASE = 32'd1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_En;
  logic          MEM_W_En;
  logic [31:0]   ALU_result;
  logic [31:0]   ST_val;
  logic [31:0]   Mem_Data;
  logic          ready;
  logic [AW-1:0] SRAM_ADDR;
  logic [31:0]   SRAM_WDATA;
  logic [31:0]   SRAM_RDATA;
  logic          SRAM_CE_N;
  logic          SRAM_WE_N;

  always #5 clk = ~clk;

  sram_mem_stage #(
    .WAIT_CYCLES(W),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_En  (MEM_R_En),
    .MEM_W_En  (MEM_W_En),
    .ALU_result(ALU_result),
    .ST_val    (ST_val),
    .Mem_Data  (Mem_Data),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA),
    .SRAM_RDATA(SRAM_RDATA),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_WE_N (SRAM_WE_N)
  );

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // External SRAM: writes on every strobed write cycle
  logic [31:0] sram [0:65535];
  bit          sram_init;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 65536; i++) sram[i] <= pat(i);
      sram_init <= 1'b1;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      sram[SRAM_ADDR] <= SRAM_WDATA;
    end
  end

  assign SRAM_RDATA = sram[SRAM_ADDR];

  // Model: pos = cycles since the request was accepted (0 = idle)
  int          pos;
  bit          m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_md;
  logic [31:0] refmem [0:65535];

  int tests;
  int fails;
  bit started;
  int nr;
  int nce;
  int nwe;
  bit rdy_s;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (!rst) return 1'b1;
    if (pos == 0) return !(MEM_R_En | MEM_W_En);
    return pos == W + 1;
  endfunction

  function automatic logic exp_strobe();
    return pos >= 1 && pos <= W;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("ready", 32'(ready), 32'(exp_ready()));
      check("ce_n", 32'(SRAM_CE_N), 32'(!exp_strobe()));
      check("we_n", 32'(SRAM_WE_N), 32'(!(exp_strobe() && m_wr)));
      check("addr", 32'(SRAM_ADDR), 32'(m_addr));
      check("wdata", SRAM_WDATA, m_wd);
      check("mem_data", Mem_Data, m_md);
    end
  end

  task automatic model_edge();
    if (!rst) begin
      pos    = 0;
      m_wr   = 1'b0;
      m_addr = '0;
      m_wd   = '0;
      m_md   = '0;
    end else if (pos == 0) begin
      if (MEM_R_En | MEM_W_En) begin
        pos    = 1;
        m_wr   = MEM_W_En;
        m_addr = 16'((ALU_result - BASE) >> 2);
        m_wd   = ST_val;
      end
    end else if (pos < W) begin
      pos++;
    end else if (pos == W) begin
      pos = W + 1;
      if (m_wr) refmem[m_addr] = m_wd;
      else m_md = refmem[m_addr];
    end else begin
      pos = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!ready) nr++;
    if (!SRAM_CE_N) nce++;
    if (!SRAM_WE_N) nwe++;
    rdy_s = ready;
    @(posedge clk);
    model_edge();
    started = 1'b1;
    #1;
  endtask

  // Issue one instruction and hold it until the stage releases it
  task automatic do_op(bit r, bit w, logic [31:0] a, logic [31:0] d);
    MEM_R_En   = r;
    MEM_W_En   = w;
    ALU_result = a;
    ST_val     = d;
    nr  = 0;
    nce = 0;
    nwe = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rdy_s) return;
    end
    check("op_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pos = 0;
    m_wr = 1'b0;
    m_addr = '0;
    m_wd = '0;
    m_md = '0;
    for (int i = 0; i < 65536; i++) refmem[i] = pat(i);

    rst        = 1'b0;
    MEM_R_En   = 1'b0;
    MEM_W_En   = 1'b1;
    ALU_result = 32'd1028;
    ST_val     = 32'hDEADBEEF;
    tick();
    check("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_mem_data", Mem_Data, 32'd0);
    tick();
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    rst = 1'b1;

    do_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("st_freeze", 32'(nr), 32'd6);
    check("st_ce_cycles", 32'(nce), 32'd5);
    check("st_we_cycles", 32'(nwe), 32'd5);
    check("st_addr", 32'(SRAM_ADDR), 32'd1);
    check("st_mem_data", Mem_Data, 32'd0);

    do_op(1'b1, 1'b0, 32'd1028, 32'd0);
    check("ld_freeze", 32'(nr), 32'd6);
    check("ld_ce_cycles", 32'(nce), 32'd5);
    check("ld_we_cycles", 32'(nwe), 32'd0);
    check("ld_data", Mem_Data, 32'hDEADBEEF);

    do_op(1'b0, 1'b1, 32'd1032, 32'h11111111);
    check("b2b_st_freeze", 32'(nr), 32'd6);
    do_op(1'b1, 1'b0, 32'd1032, 32'd0);
    check("b2b_ld_freeze", 32'(nr), 32'd6);
    check("b2b_ld_data", Mem_Data, 32'h11111111);

    do_op(1'b1, 1'b1, 32'd1036, 32'h22222222);
    check("prio_we_cycles", 32'(nwe), 32'd5);
    check("prio_mem_data", Mem_Data, 32'h11111111);
    do_op(1'b1, 1'b0, 32'd1036, 32'd0);
    check("prio_readback", Mem_Data, 32'h22222222);

    MEM_R_En = 1'b0;
    MEM_W_En = 1'b0;
    nr  = 0;
    nce = 0;
    repeat (10) tick();
    check("nop_freeze", 32'(nr), 32'd0);
    check("nop_ce_cycles", 32'(nce), 32'd0);

    // Abort a write in its third strobe cycle; data matches memory
    MEM_W_En   = 1'b1;
    ALU_result = 32'd1040;
    ST_val     = refmem[4];
    tick();
    tick();
    tick();
    rst      = 1'b0;
    MEM_W_En = 1'b0;
    tick();
    check("abort_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    check("abort_mem_data", Mem_Data, 32'd0);
    rst = 1'b1;
    tick();
    check("abort_ready", 32'(ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + (32'($urandom_range(0, 31)) << 2)
             + 32'($urandom_range(0, 3));
      do_op(kind == 1 || kind == 3, kind >= 2, a, $urandom);
    end

    MEM_R_En = 1'b0;
    MEM_W_En = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
